// File: rtl/sd_enmux_n.sv
// sd_enmux_n: srdy/drdy width-narrowing serializer.
// Takes one `width`-bit word on the consumer side and emits it as `ratio`
// narrow beats on the producer side, least-significant slice first, with
// p_last flagging the final beat of each word.
//
// Optional build macro: SD_ENMUX_N_PIPELINE_EN
//   Adds a one-word skid register ("next") so that words stream back to back
//   at ratio beats per ratio cycles. When undefined, a single holding
//   register is used and one idle cycle appears between words.
//
// state  | meaning
// -------+--------------------------------------------------------------
// EMPTY  | holding register free; accepting a word, no beat on output
// LOADED | holding register has a word; presenting slice[beat]

module sd_enmux_n #(
    parameter int width = 8,
    parameter int ratio = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                c_srdy,
    output logic                                c_drdy,
    input  logic [width-1:0]                    c_data,
    output logic                                p_srdy,
    input  logic                                p_drdy,
    output logic [(width+ratio-1)/ratio-1:0]    p_data,
    output logic                                p_last
);

    localparam int nw = (width + ratio - 1) / ratio;
    localparam int cw = (ratio > 1) ? $clog2(ratio) : 1;
    localparam int ew = nw * ratio;
    localparam logic [cw-1:0] last_beat = cw'(ratio - 1);

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [cw-1:0]   beat, beat_n;
    logic [ew-1:0]   hold, hold_n;
    logic [ew-1:0]   c_ext;
    logic            word_xfer;
    logic            beat_xfer;
    logic            final_beat;

`ifdef SD_ENMUX_N_PIPELINE_EN
    logic [ew-1:0]   next_word, next_word_n;
    logic            next_full, next_full_n;
`endif

    // Zero-extend the incoming word so pad bits of the top slice are always 0.
    assign c_ext      = ew'(c_data);
    assign word_xfer  = c_srdy & c_drdy;
    assign beat_xfer  = p_srdy & p_drdy;
    assign final_beat = (beat == last_beat);

    // Ready depends only on registered state (and reset), never on p_drdy.
`ifdef SD_ENMUX_N_PIPELINE_EN
    assign c_drdy = ~reset & ~next_full;
`else
    assign c_drdy = ~reset & (state == EMPTY);
`endif
    assign p_srdy = (state == LOADED);
    assign p_last = p_srdy & final_beat;

    // Select the current beat's slice out of the holding register.
    always_comb begin
        p_data = '0;
        for (int k = 0; k < ratio; k++) begin
            if (beat == cw'(k)) begin
                p_data = hold[k*nw +: nw];
            end
        end
    end

    // Next-state, beat counter and register-load decisions.
    always_comb begin
        state_n     = state;
        beat_n      = beat;
        hold_n      = hold;
`ifdef SD_ENMUX_N_PIPELINE_EN
        next_word_n = next_word;
        next_full_n = next_full;
`endif
        case (state)
            EMPTY: begin
                if (word_xfer) begin
                    state_n = LOADED;
                    beat_n  = '0;
                    hold_n  = c_ext;
                end
            end
            LOADED: begin
                if (beat_xfer && final_beat) begin
                    beat_n = '0;
`ifdef SD_ENMUX_N_PIPELINE_EN
                    // Refill from the skid register first so word order holds;
                    // otherwise a word arriving on this edge goes straight in.
                    if (next_full) begin
                        hold_n = next_word;
                        if (word_xfer) begin
                            next_word_n = c_ext;
                        end else begin
                            next_full_n = 1'b0;
                        end
                    end else if (word_xfer) begin
                        hold_n = c_ext;
                    end else begin
                        state_n = EMPTY;
                    end
`else
                    state_n = EMPTY;
`endif
                end else begin
                    if (beat_xfer) begin
                        beat_n = beat + 1'b1;
                    end
`ifdef SD_ENMUX_N_PIPELINE_EN
                    if (word_xfer) begin
                        next_word_n = c_ext;
                        next_full_n = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            beat      <= '0;
            hold      <= '0;
`ifdef SD_ENMUX_N_PIPELINE_EN
            next_word <= '0;
            next_full <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            hold      <= hold_n;
`ifdef SD_ENMUX_N_PIPELINE_EN
            next_word <= next_word_n;
            next_full <= next_full_n;
`endif
        end
    end

endmodule

// File: tb/tb_sd_enmux_n.sv
// Self-checking bench for sd_enmux_n: four instances with different
// width/ratio share one stimulus stream; a queue-of-beats model per instance
// predicts every output on every cycle, plus directed literal checks.
`timescale 1ns/1ps

module tb_sd_enmux_n;

    localparam int NI = 4;
    localparam int RAT [NI] = '{3, 2, 1, 7};
    localparam int NWV [NI] = '{3, 5, 5, 3};
    localparam int WV  [NI] = '{9, 9, 5, 16};

    logic        clk = 1'b0;
    logic        reset;
    logic        c_srdy;
    logic        p_drdy;
    logic [15:0] c_data;

    logic        cd [NI];
    logic        ps [NI];
    logic        pl [NI];
    logic [15:0] pd [NI];

    logic [2:0]  p_data0;
    logic [4:0]  p_data1;
    logic [4:0]  p_data2;
    logic [2:0]  p_data3;

    assign pd[0] = 16'(p_data0);
    assign pd[1] = 16'(p_data1);
    assign pd[2] = 16'(p_data2);
    assign pd[3] = 16'(p_data3);

    always #5 clk = ~clk;

    sd_enmux_n #(.width(9), .ratio(3)) u_dut0 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(cd[0]), .c_data(c_data[8:0]),
        .p_srdy(ps[0]), .p_drdy(p_drdy), .p_data(p_data0), .p_last(pl[0]));
    sd_enmux_n #(.width(9), .ratio(2)) u_dut1 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(cd[1]), .c_data(c_data[8:0]),
        .p_srdy(ps[1]), .p_drdy(p_drdy), .p_data(p_data1), .p_last(pl[1]));
    sd_enmux_n #(.width(5), .ratio(1)) u_dut2 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(cd[2]), .c_data(c_data[4:0]),
        .p_srdy(ps[2]), .p_drdy(p_drdy), .p_data(p_data2), .p_last(pl[2]));
    sd_enmux_n #(.width(16), .ratio(7)) u_dut3 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(cd[3]), .c_data(c_data),
        .p_srdy(ps[3]), .p_drdy(p_drdy), .p_data(p_data3), .p_last(pl[3]));

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned bq [NI][$];
    int words0 = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each instance owes the beats of its accepted words in order.
    logic        m_rst, m_cs, m_pdr;
    logic [15:0] m_cdat;
    logic        m_cd [NI];
    logic        m_ps [NI];
    always @(posedge clk) begin
        m_rst  = reset;
        m_cs   = c_srdy;
        m_pdr  = p_drdy;
        m_cdat = c_data;
        for (int k = 0; k < NI; k++) begin
            m_cd[k] = cd[k];
            m_ps[k] = ps[k];
        end
        for (int k = 0; k < NI; k++) begin
            if (m_rst) begin
                bq[k].delete();
            end else begin
                if (m_ps[k] && m_pdr && bq[k].size() > 0) void'(bq[k].pop_front());
                if (m_cs && m_cd[k]) begin
                    int unsigned word;
                    word = 32'(m_cdat) & ((32'h1 << WV[k]) - 1);
                    for (int b = 0; b < RAT[k]; b++)
                        bq[k].push_back((word >> (b * NWV[k])) & ((32'h1 << NWV[k]) - 1));
                    if (k == 0) words0++;
                end
            end
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            int sz, wds;
            logic exp_cd;
            sz  = bq[k].size();
            wds = (sz + RAT[k] - 1) / RAT[k];
`ifdef SD_ENMUX_N_PIPELINE_EN
            exp_cd = !reset && (wds < 2);
`else
            exp_cd = !reset && (wds == 0);
`endif
            chk($sformatf("p_srdy[%0d]", k), 16'(ps[k]), 16'(sz > 0));
            chk($sformatf("c_drdy[%0d]", k), 16'(cd[k]), 16'(exp_cd));
            chk($sformatf("p_last[%0d]", k), 16'(pl[k]),
                16'(sz > 0 && (sz % RAT[k]) == (1 % RAT[k])));
            if (sz > 0) chk($sformatf("p_data[%0d]", k), pd[k], 16'(bq[k][0]));
        end
    end

    task automatic drain();
        int t;
        logic busy;
        c_srdy = 1'b0;
        p_drdy = 1'b1;
        t = 0;
        busy = 1'b1;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
            busy = 1'b0;
            for (int k = 0; k < NI; k++) if (ps[k] || bq[k].size() > 0) busy = 1'b1;
        end
        chk("drain_busy", 16'(busy), 16'd0);
    endtask

    int cnt;
    int spct, dpct;

    initial begin
        reset  = 1'b1;
        c_srdy = 1'b0;
        p_drdy = 1'b0;
        c_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_p_srdy", 16'(ps[0]), 16'd0);
        chk("rst_p_last", 16'(pl[0]), 16'd0);
        chk("rst_p_data", pd[0], 16'd0);
        chk("rst_c_drdy", 16'(cd[0]), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_c_drdy", 16'(cd[0]), 16'd1);

        // Word 9'h1A5 through ratio 3 and ratio 2 instances.
        c_data = 16'h01A5; c_srdy = 1'b1; p_drdy = 1'b1;
        @(negedge clk); c_srdy = 1'b0;
        chk("r3_b0", pd[0], 16'h5); chk("r3_l0", 16'(pl[0]), 16'd0);
        chk("r2_b0", pd[1], 16'h05); chk("r2_l0", 16'(pl[1]), 16'd0);
        @(negedge clk);
        chk("r3_b1", pd[0], 16'h4); chk("r3_l1", 16'(pl[0]), 16'd0);
        chk("r2_b1", pd[1], 16'h0D); chk("r2_l1", 16'(pl[1]), 16'd1);
        @(negedge clk);
        chk("r3_b2", pd[0], 16'h6); chk("r3_l2", 16'(pl[0]), 16'd1);
        @(negedge clk);
        chk("r3_done_srdy", 16'(ps[0]), 16'd0);
        chk("r3_done_drdy", 16'(cd[0]), 16'd1);
        drain();

        // Stall on beat 1 for 5 cycles.
        c_data = 16'h00AB; c_srdy = 1'b1; p_drdy = 1'b1;
        @(negedge clk); c_srdy = 1'b0;
        chk("st_b0", pd[0], 16'h3);
        @(negedge clk);
        chk("st_b1", pd[0], 16'h5);
        p_drdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("st_hold_data", pd[0], 16'h5);
            chk("st_hold_srdy", 16'(ps[0]), 16'd1);
`ifndef SD_ENMUX_N_PIPELINE_EN
            chk("st_hold_drdy", 16'(cd[0]), 16'd0);
`endif
        end
        p_drdy = 1'b1;
        @(negedge clk);
        chk("st_b2", pd[0], 16'h2); chk("st_l2", 16'(pl[0]), 16'd1);
        @(negedge clk);
        chk("st_end_srdy", 16'(ps[0]), 16'd0);
        chk("st_end_drdy", 16'(cd[0]), 16'd1);
        drain();

        // Continuous load for 40 cycles, count ratio-3 beats.
        c_srdy = 1'b1; p_drdy = 1'b1; c_data = 16'($urandom);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ps[0]) cnt++;
            c_data = 16'($urandom);
        end
        c_srdy = 1'b0;
`ifdef SD_ENMUX_N_PIPELINE_EN
        chk("stream_beats_ok", 16'(cnt >= 39 && cnt <= 40), 16'd1);
`else
        chk("stream_beats", 16'(cnt), 16'd30);
`endif
        drain();

        // Reset after beat 0 of word A, then word B.
        c_data = 16'h01A5; c_srdy = 1'b1; p_drdy = 1'b1;
        @(negedge clk); c_srdy = 1'b0;
        chk("ra_b0", pd[0], 16'h5);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("ra_drdy_rst", 16'(cd[0]), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("ra_flushed", 16'(ps[0]), 16'd0);
        c_data = 16'h00AB; c_srdy = 1'b1;
        @(negedge clk); c_srdy = 1'b0;
        chk("rb_srdy", 16'(ps[0]), 16'd1);
        chk("rb_b0", pd[0], 16'h3);
        chk("rb_l0", 16'(pl[0]), 16'd0);
        drain();

        // Randomised traffic with occasional resets.
        spct = 60; dpct = 60;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (i % 1000 == 0) begin
                spct = $urandom_range(20, 100);
                dpct = $urandom_range(20, 100);
            end
            c_srdy = ($urandom % 100) < spct;
            p_drdy = ($urandom % 100) < dpct;
            c_data = 16'($urandom);
            reset  = ($urandom % 997) == 0;
        end
        @(negedge clk);
        reset = 1'b0;
        drain();
        chk("words_seen", 16'(words0 >= 300), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
